// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the Avalon-MM master arbiter.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int DEF_N_MASTERS   = 2;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Read data returned to a master whose slave access was abandoned by the watchdog.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Round-robin pointer advance: one past the winner, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             found
);

  logic [IDX_W-1:0] cand_s;

  // Scan from ptr upward, keeping only the first hit.
  always_comb begin
    found      = 1'b0;
    winner_idx = '0;
    winner     = '0;
    cand_s     = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand_s]) begin
        found      = 1'b1;
        winner_idx = cand_s;
      end else begin
        found = found;
      end
    end
    winner[winner_idx] = found;
  end

endmodule

// File: rtl/avalon_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between N_MASTERS masters.
// Optional ack watchdog enabled by defining ARB_TIMEOUT_EN.
module avalon_master_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int N_MASTERS   = DEF_N_MASTERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [N_MASTERS-1:0]          m_read,
  input  logic [N_MASTERS-1:0]          m_write,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_byte_enable,
  input  logic [N_MASTERS*DATA_W-1:0]   m_writedata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [DATA_W-1:0]             m_readdata,
  output logic                          s_read,
  output logic                          s_write,
  output logic [ADDR_W-1:0]             s_address,
  output logic [DATA_W/8-1:0]           s_byte_enable,
  output logic [DATA_W-1:0]             s_writedata,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_readdata,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int BE_W  = DATA_W / 8;

  arb_state_e             state_r;
  arb_state_e             state_nxt_s;
  logic [IDX_W-1:0]       ptr_r;
  logic [N_MASTERS-1:0]   req_s;
  logic [N_MASTERS-1:0]   pick_onehot_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_found_s;
  logic                   complete_s;
  logic                   timeout_s;

  assign req_s      = m_read | m_write;
  assign complete_s = (state_r == BUSY) && s_ack;

  rr_priority_picker #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req_s),
    .ptr        (ptr_r),
    .winner     (pick_onehot_s),
    .winner_idx (pick_idx_s),
    .found      (pick_found_s)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog counts BUSY cycles and restarts for every transaction.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wd_cnt_r <= '0;
    end else if (state_r == BUSY) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end

  // A slave ack arriving on the expiry cycle takes precedence.
  assign timeout_s = (state_r == BUSY) && !s_ack && (wd_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
  // Constant 0: the watchdog is not built.
  assign timeout_s = (TIMEOUT_CYC < 0);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE always gives one dead cycle before re-arbitration.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) state_nxt_s = BUSY;
        else              state_nxt_s = IDLE;
      end
      BUSY: begin
        if (complete_s || timeout_s) state_nxt_s = DONE;
        else                         state_nxt_s = BUSY;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Registered slave-side request, grant, pointer and master-side completion.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_r         <= '0;
      grant         <= '0;
      m_ack         <= '0;
      m_readdata    <= '0;
      s_read        <= 1'b0;
      s_write       <= 1'b0;
      s_address     <= '0;
      s_byte_enable <= '0;
      s_writedata   <= '0;
      timeout_err   <= 1'b0;
    end else begin
      m_ack       <= '0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            // Write wins when a master raises both strobes.
            s_write       <= m_write[pick_idx_s];
            s_read        <= ~m_write[pick_idx_s];
            s_address     <= m_address[int'(pick_idx_s)*ADDR_W +: ADDR_W];
            s_byte_enable <= m_byte_enable[int'(pick_idx_s)*BE_W +: BE_W];
            s_writedata   <= m_writedata[int'(pick_idx_s)*DATA_W +: DATA_W];
            grant         <= pick_onehot_s;
            ptr_r         <= IDX_W'(wrap_inc(32'(pick_idx_s), N_MASTERS));
          end else begin
            grant <= '0;
          end
        end
        BUSY: begin
          if (complete_s || timeout_s) begin
            m_ack       <= grant;
            m_readdata  <= complete_s ? s_readdata : DATA_W'(TIMEOUT_RDATA);
            timeout_err <= timeout_s;
            s_read      <= 1'b0;
            s_write     <= 1'b0;
            grant       <= '0;
          end else begin
            grant <= grant;
          end
        end
        DONE: begin
          grant <= '0;
        end
        default: begin
          grant   <= '0;
          s_read  <= 1'b0;
          s_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
